mem_arbiter_rr: RTL and testbench

- Parametrised N-channel arbiter between cache/adapter requestors and the single burst memory port (bmem).
- Successor to the fixed two-port I/D arbiter. Adds round-robin fairness across NUM_CH channels, write-burst locking, and multiple outstanding reads.
- Read responses are steered back to the issuing channel through an in-order tag FIFO.

---
 rtl/mem_arbiter_rr_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_rd_tag_fifo.sv | 46 ++++
 rtl/mem_arbiter_rr.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg: shared state encoding, default bus sizing and helpers
// for the round-robin burst memory arbiter.
package mem_arbiter_rr_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WBURST
    } arb_state_t;

    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_BYTES = DEF_BURST_LEN * DEF_DATA_W / 8;

    typedef logic [DEF_ADDR_W-1:0] bus_addr_t;
    typedef logic [DEF_DATA_W-1:0] bus_data_t;

    // Increment modulo n without relying on n being a power of two.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_rd_tag_fifo.sv
// mem_arbiter_rr_rd_tag_fifo: in-order FIFO of channel ids for outstanding
// read bursts; DEPTH must be a power of two so the pointers wrap naturally.
module mem_arbiter_rr_rd_tag_fifo
    import mem_arbiter_rr_pkg::*;
#(
    parameter int ID_W  = 1,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [ID_W-1:0] i_id,
    output logic            o_full,
    output logic            o_empty,
    output logic [ID_W-1:0] o_head
);

    localparam int PW = $clog2(DEPTH);

    logic [ID_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [PW:0]     r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wp] <= i_id;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
        end
    end

    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter of NUM_CH requestors onto one burst
// memory port, with write-burst locking and in-order read response steering.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_CH-1:0]        i_req_read,
    input  logic [NUM_CH-1:0]        i_req_write,
    input  logic [NUM_CH*DATA_W-1:0] i_req_wdata,
    output logic [NUM_CH-1:0]        o_req_ready,
    output logic [NUM_CH-1:0]        o_resp_rvalid,
    output logic [DATA_W-1:0]        o_resp_rdata,
    output logic [ADDR_W-1:0]        o_resp_raddr,
    output logic [ADDR_W-1:0]        o_bmem_addr,
    output logic                     o_bmem_read,
    output logic                     o_bmem_write,
    output logic [DATA_W-1:0]        o_bmem_wdata,
    input  logic                     i_bmem_ready,
    input  logic [ADDR_W-1:0]        i_bmem_raddr,
    input  logic [DATA_W-1:0]        i_bmem_rdata,
    input  logic                     i_bmem_rvalid,
    output logic                     o_protocol_err
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int BT_W = $clog2(BURST_LEN);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CH_W-1:0]  r_rr_ptr;
    logic [CH_W-1:0]  w_rr_nxt;
    logic [CH_W-1:0]  r_wlock;
    logic [CH_W-1:0]  w_wlock_nxt;
    logic [BT_W-1:0]  r_wbeat;
    logic [BT_W-1:0]  w_wbeat_nxt;
    logic [BT_W-1:0]  r_rbeat;
    logic             r_perr;

    logic [ADDR_W-1:0] w_addr  [NUM_CH];
    logic [DATA_W-1:0] w_wdata [NUM_CH];
    logic [NUM_CH-1:0] w_elig;
    logic [CH_W-1:0]   w_grant;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CH_W-1:0]   w_head;
    logic              w_rv;

    logic [NUM_CH-1:0] w_req_ready;
    logic [ADDR_W-1:0] w_bmem_addr;
    logic              w_bmem_read;
    logic              w_bmem_write;
    logic [DATA_W-1:0] w_bmem_wdata;

    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] idx;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_addr[c]  = i_req_addr[c*ADDR_W +: ADDR_W];
        assign w_wdata[c] = i_req_wdata[c*DATA_W +: DATA_W];
    end

    // A pop in the same cycle does not make a full FIFO eligible again.
    assign w_elig  = i_req_write | (i_req_read & {NUM_CH{~w_full}});
    assign w_grant = rr_pick(w_elig, r_rr_ptr);

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_ptr;
        w_wlock_nxt  = r_wlock;
        w_wbeat_nxt  = r_wbeat;
        w_req_ready  = '0;
        w_bmem_addr  = '0;
        w_bmem_read  = 1'b0;
        w_bmem_write = 1'b0;
        w_bmem_wdata = '0;
        w_push       = 1'b0;
        if (r_state == ST_WBURST) begin
            w_bmem_write         = 1'b1;
            w_bmem_addr          = w_addr[r_wlock];
            w_bmem_wdata         = w_wdata[r_wlock];
            w_req_ready[r_wlock] = i_bmem_ready;
            if (i_bmem_ready) begin
                w_wbeat_nxt = (r_wbeat == BT_W'(BURST_LEN-1)) ? '0 : r_wbeat + 1'b1;
                if (r_wbeat == BT_W'(BURST_LEN-1)) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = CH_W'(wrap_inc(int'(r_wlock), NUM_CH));
                end
            end
        end else if (|w_elig) begin
            w_bmem_addr          = w_addr[w_grant];
            w_req_ready[w_grant] = i_bmem_ready;
            if (i_req_write[w_grant]) begin
                w_bmem_write = 1'b1;
                w_bmem_wdata = w_wdata[w_grant];
                w_state_nxt  = ST_WBURST;
                w_wlock_nxt  = w_grant;
                w_wbeat_nxt  = BT_W'(i_bmem_ready);
            end else begin
                w_bmem_read = 1'b1;
                w_push      = i_bmem_ready;
                w_rr_nxt    = i_bmem_ready ? CH_W'(wrap_inc(int'(w_grant), NUM_CH)) : r_rr_ptr;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_wlock  <= '0;
            r_wbeat  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_wlock  <= w_wlock_nxt;
            r_wbeat  <= w_wbeat_nxt;
        end
    end

    // Returned beats belong to the oldest outstanding burst.
    assign w_rv  = i_bmem_rvalid & ~w_empty;
    assign w_pop = w_rv & (r_rbeat == BT_W'(BURST_LEN-1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rbeat <= '0;
            r_perr  <= 1'b0;
        end else begin
            if (w_rv) r_rbeat <= w_pop ? '0 : r_rbeat + 1'b1;
            if (i_bmem_rvalid && w_empty) r_perr <= 1'b1;
        end
    end

    mem_arbiter_rr_rd_tag_fifo #(
        .ID_W  (CH_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_id    (w_grant),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Combinational outputs are forced low while reset is held.
    assign o_req_ready    = i_rst_n ? w_req_ready : '0;
    assign o_bmem_addr    = i_rst_n ? w_bmem_addr : '0;
    assign o_bmem_read    = i_rst_n & w_bmem_read;
    assign o_bmem_write   = i_rst_n & w_bmem_write;
    assign o_bmem_wdata   = i_rst_n ? w_bmem_wdata : '0;
    assign o_resp_rvalid  = w_rv ? (NUM_CH'(1) << w_head) : '0;
    assign o_resp_rdata   = i_rst_n ? i_bmem_rdata : '0;
    assign o_resp_raddr   = i_rst_n ? i_bmem_raddr : '0;
    assign o_protocol_err = r_perr;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed scenarios plus a randomized run checked against
// a queue-based behavioural model of the arbiter.
module tb_mem_arbiter_rr;

    localparam int NC = 2, BL = 4, MO = 4, AW = 32, DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NC*AW-1:0] req_addr;
    logic [NC-1:0]    req_read, req_write;
    logic [NC*DW-1:0] req_wdata;
    logic [NC-1:0]    req_ready, resp_rvalid;
    logic [DW-1:0]    resp_rdata, bmem_wdata, bmem_rdata;
    logic [AW-1:0]    resp_raddr, bmem_addr, bmem_raddr;
    logic             bmem_read, bmem_write, bmem_ready, bmem_rvalid, protocol_err;

    int errs = 0, checks = 0;

    mem_arbiter_rr #(.NUM_CH(NC), .BURST_LEN(BL), .MAX_OUTST(MO), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_addr(req_addr), .i_req_read(req_read),
        .i_req_write(req_write), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
        .o_resp_rvalid(resp_rvalid), .o_resp_rdata(resp_rdata), .o_resp_raddr(resp_raddr),
        .o_bmem_addr(bmem_addr), .o_bmem_read(bmem_read), .o_bmem_write(bmem_write),
        .o_bmem_wdata(bmem_wdata), .i_bmem_ready(bmem_ready), .i_bmem_raddr(bmem_raddr),
        .i_bmem_rdata(bmem_rdata), .i_bmem_rvalid(bmem_rvalid), .o_protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_addr = '0; req_read = '0; req_write = '0; req_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        req_read = 2'b11; req_write = 2'b11;
        req_addr = {32'h200, 32'h100}; req_wdata = {64'h22, 64'h11};
        bmem_ready = 1'b1; bmem_rvalid = 1'b1; bmem_rdata = 64'h55; bmem_raddr = 32'h77;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if ({bmem_read, bmem_write} !== 2'b00) begin errs++; $display("FAIL reset_bmem_cmd got %b want 00", {bmem_read, bmem_write}); end
        checks++; if (bmem_addr !== '0 || bmem_wdata !== '0) begin errs++; $display("FAIL reset_bmem_bus got %h/%h want 0/0", bmem_addr, bmem_wdata); end
        checks++; if (resp_rvalid !== 2'b00 || protocol_err !== 1'b0) begin errs++; $display("FAIL reset_resp got %b/%b want 00/0", resp_rvalid, protocol_err); end
        checks++; if (resp_rdata !== '0 || resp_raddr !== '0) begin errs++; $display("FAIL reset_resp_bus got %h/%h want 0/0", resp_rdata, resp_raddr); end
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        req_read = 2'b01; req_addr[31:0] = 32'h100; bmem_ready = 1'b1;
        #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h100) begin errs++; $display("FAIL rd_cmd got %b/%h want 1/100", bmem_read, bmem_addr); end
        checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL rd_ready got %b want 01", req_ready); end
        tick();
        req_read = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b00 || bmem_read !== 1'b0) begin errs++; $display("FAIL rd_ready_pulse got %b/%b want 00/0", req_ready, bmem_read); end
        for (int b = 0; b < BL; b++) begin
            bmem_rvalid = 1'b1; bmem_rdata = 64'hA000 + 64'(b); bmem_raddr = 32'h100;
            #1;
            checks++; if (resp_rvalid !== 2'b01) begin errs++; $display("FAIL rd_steer beat %0d got %b want 01", b, resp_rvalid); end
            checks++; if (resp_rdata !== 64'hA000 + 64'(b) || resp_raddr !== 32'h100) begin errs++; $display("FAIL rd_data beat %0d got %h/%h", b, resp_rdata, resp_raddr); end
            tick();
        end
        bmem_rvalid = 1'b1;
        #1;
        checks++; if (resp_rvalid !== 2'b00) begin errs++; $display("FAIL rd_fifth_beat got %b want 00", resp_rvalid); end
        tick();
        bmem_rvalid = 1'b0;
    endtask

    task automatic test_alternating;
        do_reset();
        req_read = 2'b11; req_addr = {32'h2000, 32'h1000}; bmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req_ready !== ((i % 2) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL alt_grant %0d got %b", i, req_ready); end
            checks++; if (bmem_addr !== ((i % 2) ? 32'h2000 : 32'h1000)) begin errs++; $display("FAIL alt_addr %0d got %h", i, bmem_addr); end
            tick();
        end
        req_read = 2'b00;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < BL; b++) begin
                bmem_rvalid = 1'b1; bmem_rdata = 64'(s * 16 + b);
                #1;
                checks++; if (resp_rvalid !== ((s % 2) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL alt_steer burst %0d beat %0d got %b", s, b, resp_rvalid); end
                tick();
            end
        end
        bmem_rvalid = 1'b0;
    endtask

    task automatic test_outstanding;
        do_reset();
        req_read = 2'b01; req_addr[31:0] = 32'h4000; bmem_ready = 1'b1;
        for (int i = 0; i < MO; i++) begin
            #1;
            checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL outst_grant %0d got %b want 01", i, req_ready); end
            tick();
        end
        #1;
        checks++; if (bmem_read !== 1'b0 || req_ready !== 2'b00 || bmem_addr !== '0) begin errs++; $display("FAIL outst_full got %b/%b/%h want 0/00/0", bmem_read, req_ready, bmem_addr); end
        tick();
        for (int b = 0; b < BL; b++) begin
            bmem_rvalid = 1'b1;
            #1;
            checks++; if (bmem_read !== 1'b0) begin errs++; $display("FAIL outst_pop_hold beat %0d got %b want 0", b, bmem_read); end
            tick();
        end
        bmem_rvalid = 1'b0;
        #1;
        checks++; if (bmem_read !== 1'b1 || req_ready !== 2'b01) begin errs++; $display("FAIL outst_after_pop got %b/%b want 1/01", bmem_read, req_ready); end
        tick();
        req_read = 2'b00;
    endtask

    task automatic test_write_burst;
        logic [DW-1:0] wv [4];
        logic [4:0] rdy_seq;
        int bi;
        wv[0] = 64'hAAAA; wv[1] = 64'hBBBB; wv[2] = 64'hCCCC; wv[3] = 64'hDDDD;
        rdy_seq = 5'b11101;
        bi = 0;
        do_reset();
        req_write = 2'b10; req_addr[63:32] = 32'h200;
        for (int k = 0; k < 5; k++) begin
            req_wdata[127:64] = wv[bi]; bmem_ready = rdy_seq[k];
            if (k == 1) begin req_read[0] = 1'b1; req_addr[31:0] = 32'h300; end
            #1;
            checks++; if ({bmem_write, bmem_read} !== 2'b10 || bmem_addr !== 32'h200) begin errs++; $display("FAIL wr_cmd %0d got %b/%h want 10/200", k, {bmem_write, bmem_read}, bmem_addr); end
            checks++; if (bmem_wdata !== wv[bi]) begin errs++; $display("FAIL wr_data %0d got %h want %h", k, bmem_wdata, wv[bi]); end
            checks++; if (req_ready !== (rdy_seq[k] ? 2'b10 : 2'b00)) begin errs++; $display("FAIL wr_ready %0d got %b", k, req_ready); end
            tick();
            if (rdy_seq[k]) bi++;
        end
        req_write = 2'b00; bmem_ready = 1'b1;
        #1;
        checks++; if ({bmem_write, bmem_read} !== 2'b01 || bmem_addr !== 32'h300 || req_ready !== 2'b01) begin errs++; $display("FAIL wr_then_read got %b/%h/%b want 01/300/01", {bmem_write, bmem_read}, bmem_addr, req_ready); end
        tick();
        req_read = 2'b00;
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req_write = 2'b10; req_addr[63:32] = 32'h500; req_wdata[127:64] = 64'h1; bmem_ready = 1'b1;
        tick();
        req_wdata[127:64] = 64'h2;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00 || {bmem_write, bmem_read} !== 2'b00) begin errs++; $display("FAIL rst_mid_cmd got %b/%b want 00/00", req_ready, {bmem_write, bmem_read}); end
        checks++; if (bmem_addr !== '0 || bmem_wdata !== '0) begin errs++; $display("FAIL rst_mid_bus got %h/%h want 0/0", bmem_addr, bmem_wdata); end
        #2;
        clear_inputs();
        req_read = 2'b11; req_addr = {32'h700, 32'h600}; bmem_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01 || bmem_addr !== 32'h600) begin errs++; $display("FAIL rst_mid_first got %b/%h want 01/600", req_ready, bmem_addr); end
        tick();
        req_read = 2'b00;
    endtask

    task automatic test_spurious;
        do_reset();
        bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD;
        #1;
        checks++; if (resp_rvalid !== 2'b00 || protocol_err !== 1'b0) begin errs++; $display("FAIL spur_resp got %b/%b want 00/0", resp_rvalid, protocol_err); end
        tick();
        bmem_rvalid = 1'b0;
        #1;
        checks++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL spur_err got %b want 1", protocol_err); end
        tick(); tick();
        checks++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL spur_sticky got %b want 1", protocol_err); end
    endtask

    task automatic test_random;
        int m_rr, m_wlock, m_wb, m_rb, g, mem_beat;
        bit m_busy, g_wr, issued;
        int m_q[$];
        logic [AW-1:0] mem_q[$];
        logic [AW-1:0] iaddr, exp_addr;
        logic [DW-1:0] exp_wd;
        logic [NC-1:0] exp_rdy, exp_rv, rdy_s;
        logic exp_rd, exp_wr;
        int mode[NC], wbeats[NC];
        do_reset();
        m_rr = 0; m_wlock = 0; m_wb = 0; m_rb = 0; m_busy = 0; mem_beat = 0;
        for (int c = 0; c < NC; c++) begin mode[c] = 0; wbeats[c] = 0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            bmem_ready  = ($urandom_range(0, 3) != 0);
            bmem_rvalid = (mem_q.size() > 0) && ($urandom_range(0, 1) == 1);
            bmem_raddr  = bmem_rvalid ? mem_q[0] : '0;
            bmem_rdata  = bmem_rvalid ? {mem_q[0], 32'(mem_beat)} : '0;
            #1;
            exp_rdy = '0; exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wd = '0; g = -1; g_wr = 0;
            if (m_busy) begin
                exp_wr = 1; exp_addr = req_addr[m_wlock*AW +: AW]; exp_wd = req_wdata[m_wlock*DW +: DW];
                exp_rdy[m_wlock] = bmem_ready;
            end else begin
                for (int k = 0; k < NC; k++) begin
                    int c;
                    c = (m_rr + k) % NC;
                    if (g < 0 && (req_write[c] || (req_read[c] && m_q.size() < MO))) g = c;
                end
                if (g >= 0) begin
                    g_wr = req_write[g];
                    exp_addr = req_addr[g*AW +: AW]; exp_rdy[g] = bmem_ready;
                    if (g_wr) begin exp_wr = 1; exp_wd = req_wdata[g*DW +: DW]; end
                    else exp_rd = 1;
                end
            end
            exp_rv = (bmem_rvalid && m_q.size() > 0) ? (NC'(1) << m_q[0]) : '0;
            checks++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, req_ready, exp_rdy); end
            checks++; if ({bmem_read, bmem_write} !== {exp_rd, exp_wr}) begin errs++; $display("FAIL rnd_cmd cyc %0d got %b want %b", cyc, {bmem_read, bmem_write}, {exp_rd, exp_wr}); end
            checks++; if (bmem_addr !== exp_addr || bmem_wdata !== exp_wd) begin errs++; $display("FAIL rnd_bus cyc %0d got %h/%h want %h/%h", cyc, bmem_addr, bmem_wdata, exp_addr, exp_wd); end
            checks++; if (resp_rvalid !== exp_rv) begin errs++; $display("FAIL rnd_rvalid cyc %0d got %b want %b", cyc, resp_rvalid, exp_rv); end
            if (exp_rv != '0) begin
                checks++; if (resp_rdata !== bmem_rdata || resp_raddr !== mem_q[0]) begin errs++; $display("FAIL rnd_rdata cyc %0d got %h/%h", cyc, resp_rdata, resp_raddr); end
            end
            rdy_s = req_ready; issued = bmem_read && bmem_ready; iaddr = bmem_addr;
            tick();
            if (m_busy) begin
                if (bmem_ready) begin
                    m_wb++;
                    if (m_wb == BL) begin m_busy = 0; m_rr = (m_wlock + 1) % NC; end
                end
            end else if (g >= 0) begin
                if (g_wr) begin m_busy = 1; m_wlock = g; m_wb = bmem_ready ? 1 : 0; end
                else if (bmem_ready) begin m_q.push_back(g); m_rr = (g + 1) % NC; end
            end
            if (bmem_rvalid && m_q.size() > 0) begin
                m_rb++;
                if (m_rb == BL) begin void'(m_q.pop_front()); m_rb = 0; end
            end
            if (bmem_rvalid) begin
                mem_beat++;
                if (mem_beat == BL) begin void'(mem_q.pop_front()); mem_beat = 0; end
            end
            if (issued) mem_q.push_back(iaddr);
            for (int c = 0; c < NC; c++) begin
                if (mode[c] == 1 && rdy_s[c]) begin mode[c] = 0; req_read[c] = 1'b0; end
                if (mode[c] == 2 && rdy_s[c]) begin
                    wbeats[c]++;
                    if (wbeats[c] == BL) begin mode[c] = 0; req_write[c] = 1'b0; end
                    else req_wdata[c*DW +: DW] = {$urandom, $urandom};
                end
                if (mode[c] == 0 && $urandom_range(0, 2) == 0) begin
                    req_addr[c*AW +: AW] = {$urandom_range(0, 32'h7FFFFFF), 5'b0};
                    if ($urandom_range(0, 1) == 1) begin mode[c] = 1; req_read[c] = 1'b1; end
                    else begin
                        mode[c] = 2; wbeats[c] = 0; req_write[c] = 1'b1;
                        req_wdata[c*DW +: DW] = {$urandom, $urandom};
                    end
                end
            end
        end
        checks++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL rnd_perr got %b want 0", protocol_err); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternating();
        test_outstanding();
        test_write_burst();
        test_reset_mid_burst();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
